pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter controller for the 12-bit instruction address space.
- Holds the PC and fetches each instruction from instruction memory over a req/ack handshake.
- Waits for the decoder's control verdict, then selects the next PC: sequential (pc+1), PC-relative branch (pc+1+signed 8-bit disp), absolute jump, call or return.
- Has a small internal return-address stack.

Parameters:
- ADDR_W, 12, PC / instruction address width.
- DISP_W, 8, branch displacement width (two's complement).
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥2).
- RESET_ADDR, 12'h000, PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held high until acked.
- imem_addr  out  ADDR_W  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  fetch done; instruction valid to decoder this cycle.
- ctrl_valid  in  1  decoder verdict valid (sampled only in EXEC).
- ctrl_op  in  3  0=SEQ 1=BR 2=JMP 3=CALL 4=RET 5=HALT; 6,7 treated as SEQ.
- br_taken  in  1  branch condition, used only when ctrl_op=BR.
- br_disp  in  DISP_W  signed displacement for BR and CALL.
- jmp_addr  in  ADDR_W  absolute target for JMP.
- pc  out  ADDR_W  current PC.
- halted  out  1  high in HALT state.
- stack_err  out  1  sticky: call on full stack or return on empty stack.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, pc=RESET_ADDR, stack pointer=0, stack contents=0, stack_err=0, halted=0, imem_req=0. imem_addr=pc.
- FETCH:
  - First cycle after reset release: drive imem_req=1.
  - Hold imem_req and imem_addr stable until imem_ack=1.
  - On ack, drop imem_req next cycle and go to EXEC.
  - An ack arriving in the same cycle as imem_req rises is legal; minimum fetch latency is 1 cycle.
- EXEC:
  - imem_req=0. Wait for ctrl_valid; ctrl_valid outside EXEC is ignored.
  - On ctrl_valid, pc updates at the next edge and state returns to FETCH, except HALT and error cases below.
- Next-PC arithmetic, all modulo 2^ADDR_W with silent wrap and no flags:
  - seq = pc+1.
  - rel = pc + 1 + sign_extend(br_disp): disp ≥ 0x80 subtracts 256, e.g. disp 0xFE is −2.
- Op selection:
  - SEQ: pc←seq.
  - BR: pc←rel if br_taken, else seq.
  - JMP: pc←jmp_addr.
  - CALL: push seq, pc←rel.
  - RET: pop, pc←popped value.
  - HALT: pc unchanged, state→HALT.
- Stack:
  - LIFO; sp counts entries, 0..STACK_DEPTH.
  - CALL with sp=STACK_DEPTH: no push, pc unchanged, stack_err←1, state→HALT.
  - RET with sp=0: pc unchanged, stack_err←1, state→HALT.
- HALT: halted=1, imem_req=0, all inputs ignored; exit only via reset.
- stack_err clears only on reset.
- Reset asserted mid-fetch (imem_req high) drops imem_req immediately (async). Any late imem_ack after reset release is ignored unless imem_req=1.
- pc is registered; it changes only on the EXEC→FETCH edge or at reset.

Test Plan:
- Reset then SEQ ×3 with imem_ack 1 cycle after req → imem_addr sequence 0x000, 0x001, 0x002, 0x003; imem_req never high in EXEC.
- pc=0x005, BR taken, disp=0xFE → next fetch 0x004. Same with br_taken=0 → 0x006.
- Wrap cases:
  - pc=0x000, BR taken, disp=0x80 → 0xF81.
  - pc=0xFFE, BR taken, disp=0x7F → 0x07E.
  - pc=0xFFF, SEQ → 0x000.
- Nesting: CALL at 0x010 (disp 0x10) → 0x021; CALL at 0x021 (disp 0x00) → 0x022; RET → 0x022; RET → 0x011.
- Stack error: fifth nested CALL with STACK_DEPTH=4 → stack_err=1, halted=1, pc unchanged, no further imem_req. Separately, RET after reset → same error response.
- Fetch stall and reset:
  - imem_ack delayed 5 cycles → imem_req and imem_addr stable throughout.
  - rst_n pulsed low mid-fetch → imem_req=0 in the same cycle, pc=0x000, refetch from 0x000.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter controller: fetches over a req/ack handshake, then picks the next PC
// from the decoder verdict (seq / branch / jump / call / return) with a small return stack.
module pc_sequencer #(
  parameter int              ADDR_W      = 12,
  parameter int              DISP_W      = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 12'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              ctrl_valid,
  input  logic [2:0]        ctrl_op,
  input  logic              br_taken,
  input  logic [DISP_W-1:0] br_disp,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              stack_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;

  state_t            state, state_nxt;
  logic              req, req_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic              push, pop, err_set;
  logic [ADDR_W-1:0] seq_pc, rel_pc, top;

  assign seq_pc = pc + ADDR_W'(1);
  assign rel_pc = seq_pc + {{(ADDR_W-DISP_W){br_disp[DISP_W-1]}}, br_disp};
  assign top    = stack[IDX_W'(sp - SP_W'(1))];

  assign imem_req  = req;
  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    pc_nxt    = pc;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_FETCH: begin
        // req rises one cycle after entering FETCH from reset; acks only count while req is up
        if (!req) begin
          req_nxt = 1'b1;
        end else if (imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ctrl_valid) begin
          state_nxt = ST_FETCH;
          req_nxt   = 1'b1;
          case (ctrl_op)
            OP_BR:   pc_nxt = br_taken ? rel_pc : seq_pc;
            OP_JMP:  pc_nxt = jmp_addr;
            OP_CALL: begin
              if (sp == SP_FULL) begin
                err_set = 1'b1;
              end else begin
                push   = 1'b1;
                pc_nxt = rel_pc;
              end
            end
            OP_RET: begin
              if (sp == '0) begin
                err_set = 1'b1;
              end else begin
                pop    = 1'b1;
                pc_nxt = top;
              end
            end
            OP_HALT: state_nxt = ST_HALT;
            default: pc_nxt = seq_pc;
          endcase
          if (err_set) state_nxt = ST_HALT;
          if (state_nxt == ST_HALT) req_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      req       <= 1'b0;
      pc        <= RESET_ADDR;
      sp        <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      pc    <= pc_nxt;
      if (err_set) stack_err <= 1'b1;
      if (push) begin
        stack[IDX_W'(sp)] <= seq_pc;
        sp                <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= sp - SP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference PC/stack model queues the expected fetch
// address on each verdict; the fetch responder pops and compares when the DUT requests.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        ctrl_valid = 1'b0;
  logic [2:0]  ctrl_op = 3'd0;
  logic        br_taken = 1'b0;
  logic [7:0]  br_disp = 8'd0;
  logic [11:0] jmp_addr = 12'd0;
  logic [11:0] pc;
  logic        halted;
  logic        stack_err;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .ctrl_valid(ctrl_valid), .ctrl_op(ctrl_op), .br_taken(br_taken),
    .br_disp(br_disp), .jmp_addr(jmp_addr),
    .pc(pc), .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mpc;
  int          msp;
  logic [11:0] mstk [4];
  logic        merr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mpc  = 12'h000;
    msp  = 0;
    merr = 1'b0;
    exp_q.delete();
    exp_q.push_back(12'h000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b0;
    ctrl_valid = 1'b0;
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stack_err", stack_err, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Answer one fetch; lat = number of cycles req is high up to and including the ack cycle.
  task automatic fetch(input int lat);
    int t;
    logic [11:0] e, a0;
    logic bad;
    t = 0;
    while (imem_req !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (imem_req !== 1'b1) begin
      chk("req_timeout", imem_req, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("sb_empty", imem_addr, 12'hxxx);
      e = imem_addr;
    end else begin
      e = exp_q.pop_front();
    end
    chk("fetch_addr", imem_addr, e);
    a0  = imem_addr;
    bad = 1'b0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== a0) bad = 1'b1;
    end
    if (lat > 1) chk("stall_stable", bad, 0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("req_drop", imem_req, 0);
  endtask

  task automatic exec(input logic [2:0] op, input logic tk, input logic [7:0] d,
                      input logic [11:0] ja);
    logic [11:0] seq, rel;
    logic halt_e;
    chk("req_in_exec", imem_req, 0);
    seq    = mpc + 12'd1;
    rel    = seq + {{4{d[7]}}, d};
    halt_e = 1'b0;
    case (op)
      3'd1: mpc = tk ? rel : seq;
      3'd2: mpc = ja;
      3'd3: begin
        if (msp == 4) begin halt_e = 1'b1; merr = 1'b1; end
        else begin mstk[msp] = seq; msp++; mpc = rel; end
      end
      3'd4: begin
        if (msp == 0) begin halt_e = 1'b1; merr = 1'b1; end
        else begin msp--; mpc = mstk[msp]; end
      end
      3'd5: halt_e = 1'b1;
      default: mpc = seq;
    endcase
    ctrl_op = op; br_taken = tk; br_disp = d; jmp_addr = ja;
    ctrl_valid = 1'b1;
    @(negedge clk);
    ctrl_valid = 1'b0;
    if (halt_e) begin
      chk("halted", halted, 1);
      chk("halt_stack_err", stack_err, merr);
      chk("halt_pc", pc, mpc);
    end else begin
      chk("not_halted", halted, 0);
      exp_q.push_back(mpc);
    end
  endtask

  task automatic no_req_window();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0) seen = 1'b1;
    end
    chk("halt_no_req", seen, 0);
    chk("halt_sticky", halted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    model_reset();
    do_reset();

    // sequential fetches with 1-cycle ack latency
    fetch(2); exec(3'd0, 0, 8'h00, 0);
    fetch(2); exec(3'd0, 0, 8'h00, 0);
    fetch(1); exec(3'd6, 0, 8'h00, 0);
    fetch(1);

    // branches around 0x005
    exec(3'd2, 0, 8'h00, 12'h005); fetch(1);
    exec(3'd1, 1, 8'hFE, 0);       fetch(1);
    exec(3'd2, 0, 8'h00, 12'h005); fetch(1);
    exec(3'd1, 0, 8'hFE, 0);       fetch(1);

    // wrap cases
    exec(3'd2, 0, 8'h00, 12'h000); fetch(1);
    exec(3'd1, 1, 8'h80, 0);       fetch(1);
    exec(3'd2, 0, 8'h00, 12'hFFE); fetch(1);
    exec(3'd1, 1, 8'h7F, 0);       fetch(1);
    exec(3'd2, 0, 8'h00, 12'hFFF); fetch(1);
    exec(3'd7, 0, 8'h00, 0);       fetch(1);

    // nested call / return
    exec(3'd2, 0, 8'h00, 12'h010); fetch(1);
    exec(3'd3, 0, 8'h10, 0);       fetch(1);
    exec(3'd3, 0, 8'h00, 0);       fetch(1);
    exec(3'd4, 0, 8'h00, 0);       fetch(1);
    exec(3'd4, 0, 8'h00, 0);

    // ack delayed 5 cycles, then reset mid-fetch
    fetch(6);
    exec(3'd0, 0, 8'h00, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_req", imem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", imem_req, 0);
    chk("async_pc", pc, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fetch(3);

    // overflow on fifth nested call
    for (int i = 0; i < 4; i++) begin
      exec(3'd3, 0, 8'h00, 0);
      fetch(1);
    end
    exec(3'd3, 0, 8'h00, 0);
    no_req_window();

    // return on empty stack
    do_reset();
    fetch(1);
    exec(3'd4, 0, 8'h00, 0);
    no_req_window();

    // explicit halt leaves stack_err clear
    do_reset();
    fetch(2);
    exec(3'd5, 0, 8'h00, 0);
    no_req_window();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
